// File: rtl/ps_phase_if.sv
// Dynamic phase-shift handshake between an initiator (fine-delay controller)
// and a responder (MMCM PS port or its fabric emulation).
interface ps_phase_if;
  logic ps_en;
  logic ps_incdec;
  logic ps_done;
  logic busy;

  modport master (output ps_en, output ps_incdec, input ps_done, input busy);
  modport slave  (input ps_en, input ps_incdec, output ps_done, output busy);
endinterface

// File: rtl/ps_phase_responder.sv
// Fabric emulation of the MMCM dynamic phase-shift port: one step at a time,
// fixed-latency ps_done, phase position tracked modulo one period.
module ps_phase_responder #(
  parameter int STEPS_PER_PERIOD = 497,
  parameter int PS_LATENCY       = 12,
  localparam int PW              = $clog2(STEPS_PER_PERIOD)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          err_clear,
  ps_phase_if.slave     ps,
  output logic [PW-1:0] phase_pos,
  output logic          tap_load,
  output logic          overrun_err
);

  localparam int CW = $clog2(PS_LATENCY + 1);
  localparam logic [PW-1:0] LAST_POS = PW'(STEPS_PER_PERIOD - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dir_q, dir_d;
  logic [PW-1:0] pos_q, pos_d;
  logic          err_q, err_d;
  logic          overrun;

  // Explicit wrap in both directions keeps the position in range when the
  // period is not a power of two.
  function automatic logic [PW-1:0] step_pos(input logic [PW-1:0] p, input logic up);
    if (up)
      return (p == LAST_POS) ? '0 : p + PW'(1);
    else
      return (p == '0) ? LAST_POS : p - PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      pos_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      pos_q   <= pos_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    pos_d   = pos_q;
    case (state_q)
      S_IDLE: begin
        if (ps.ps_en && enable) begin
          dir_d   = ps.ps_incdec;
          cnt_d   = CW'(PS_LATENCY - 1);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        // Position is committed on entry to DONE so it is visible with ps_done.
        if (cnt_q == CW'(1)) begin
          pos_d   = step_pos(pos_q, dir_q);
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // A request while a step is in flight is dropped; set beats clear.
  always_comb begin
    overrun = ps.ps_en && (state_q != S_IDLE);
    err_d   = err_q;
    if (overrun)
      err_d = 1'b1;
    else if (err_clear)
      err_d = 1'b0;
  end

  assign ps.ps_done  = (state_q == S_DONE);
  assign ps.busy     = (state_q != S_IDLE);
  assign tap_load    = (state_q == S_DONE);
  assign phase_pos   = pos_q;
  assign overrun_err = err_q;

endmodule

// File: tb/tb_ps_phase_responder.sv
// Directed bench for ps_phase_responder: a per-cycle vector table plus
// hand-written sequences for overrun, gating, wrap, mid-step reset and a random stream.
module tb_ps_phase_responder;
  localparam int SPP = 497;
  localparam int LAT = 12;
  localparam int PW  = $clog2(SPP);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b1;
  logic          err_clear = 1'b0;
  logic [PW-1:0] phase_pos;
  logic          tap_load;
  logic          overrun_err;

  ps_phase_if psif ();

  ps_phase_responder #(.STEPS_PER_PERIOD(SPP), .PS_LATENCY(LAT)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .err_clear   (err_clear),
    .ps          (psif.slave),
    .phase_pos   (phase_pos),
    .tap_load    (tap_load),
    .overrun_err (overrun_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic en, incdec, ena, clr;
    logic done, busy, err;
    int   pos;
  } vec_t;

  vec_t vecs[$];
  int   ncmp = 0;
  int   nfail = 0;
  int   model = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic void add(input logic en, input logic incdec, input logic ena, input logic clr,
                              input logic done, input logic busy, input int pos, input logic err);
    vec_t v;
    v.en = en; v.incdec = incdec; v.ena = ena; v.clr = clr;
    v.done = done; v.busy = busy; v.pos = pos; v.err = err;
    vecs.push_back(v);
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    psif.ps_en = 1'b0;
    psif.ps_incdec = 1'b0;
    enable = 1'b1;
    err_clear = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    model = 0;
  endtask

  // One step from idle; checks exact latency, position and tap_load, then
  // spends the extra cycle after ps_done so the next request is accepted.
  task automatic do_step(input logic up, input int drop_en_at, input string tag);
    int lat;
    bit seen;
    seen = 1'b0;
    lat = 0;
    psif.ps_en = 1'b1;
    psif.ps_incdec = up;
    for (int k = 1; k <= LAT + 8 && !seen; k++) begin
      tick();
      if (k == 1) begin
        psif.ps_en = 1'b0;
        psif.ps_incdec = ~up;
      end
      if (k == drop_en_at) enable = 1'b0;
      if (psif.ps_done) begin
        seen = 1'b1;
        lat = k;
      end
    end
    model = up ? ((model + 1) % SPP) : ((model + SPP - 1) % SPP);
    if (!seen) begin
      chk({tag, "_done_timeout"}, 0, 1);
    end else begin
      chk({tag, "_latency"}, lat, LAT);
      chk({tag, "_tap_load"}, tap_load, 1);
      chk({tag, "_pos"}, phase_pos, model);
    end
    tick();
    enable = 1'b1;
  endtask

  initial begin
    int dones;
    psif.ps_en = 1'b0;
    psif.ps_incdec = 1'b0;

    // Table: single inc from 0, a dropped request, then a dec back to 0
    // with ps_incdec toggled during WAIT.
    add(1, 1, 1, 0, 0, 1, 0, 0);
    for (int i = 0; i < LAT - 2; i++) add(0, 0, 1, 0, 0, 1, 0, 0);
    add(0, 0, 1, 0, 1, 1, 1, 0);
    add(0, 1, 1, 0, 0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 0, 1, 0);
    add(1, 0, 1, 1, 0, 1, 1, 0);
    for (int i = 0; i < LAT - 2; i++) add(0, i[0], 1, 0, 0, 1, 1, 0);
    add(0, 0, 1, 0, 1, 1, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0);

    rst = 1'b1;
    tick();
    chk("reset_done", psif.ps_done, 0);
    chk("reset_busy", psif.busy, 0);
    chk("reset_pos", phase_pos, 0);
    chk("reset_tap", tap_load, 0);
    chk("reset_err", overrun_err, 0);
    do_reset();

    foreach (vecs[i]) begin
      psif.ps_en = vecs[i].en;
      psif.ps_incdec = vecs[i].incdec;
      enable = vecs[i].ena;
      err_clear = vecs[i].clr;
      tick();
      chk($sformatf("vec%0d_done", i), psif.ps_done, vecs[i].done);
      chk($sformatf("vec%0d_tap", i), tap_load, vecs[i].done);
      chk($sformatf("vec%0d_busy", i), psif.busy, vecs[i].busy);
      chk($sformatf("vec%0d_pos", i), phase_pos, vecs[i].pos);
      chk($sformatf("vec%0d_err", i), overrun_err, vecs[i].err);
    end
    psif.ps_en = 1'b0;
    enable = 1'b1;
    err_clear = 1'b0;

    // Wrap both ways.
    do_reset();
    do_step(1'b0, 0, "dec_wrap");
    chk("dec_wrap_496", phase_pos, 496);
    do_step(1'b1, 0, "inc_wrap");
    chk("inc_wrap_0", phase_pos, 0);
    for (int i = 0; i < SPP; i++) do_step(1'b1, 0, "full_period");
    chk("full_period_pos", phase_pos, 0);

    // Overrun during WAIT, simultaneous set/clear, then clear alone.
    do_reset();
    psif.ps_en = 1'b1;
    psif.ps_incdec = 1'b1;
    tick();
    psif.ps_en = 1'b0;
    for (int i = 2; i <= 5; i++) tick();
    psif.ps_en = 1'b1;
    psif.ps_incdec = 1'b0;
    tick();
    chk("ovr_set", overrun_err, 1);
    err_clear = 1'b1;
    tick();
    chk("ovr_set_wins", overrun_err, 1);
    psif.ps_en = 1'b0;
    tick();
    chk("ovr_cleared", overrun_err, 0);
    err_clear = 1'b0;
    for (int i = 9; i <= LAT; i++) tick();
    chk("ovr_done", psif.ps_done, 1);
    chk("ovr_pos", phase_pos, 1);
    tick();
    chk("ovr_idle_busy", psif.busy, 0);
    model = 1;

    // Gating: request while disabled is dropped silently.
    enable = 1'b0;
    psif.ps_en = 1'b1;
    psif.ps_incdec = 1'b1;
    tick();
    psif.ps_en = 1'b0;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      if (psif.ps_done) dones++;
      tick();
    end
    chk("gate_no_done", dones, 0);
    chk("gate_no_err", overrun_err, 0);
    chk("gate_pos", phase_pos, 1);
    enable = 1'b1;
    do_step(1'b1, 3, "enable_drop");

    // Reset mid-step aborts without ps_done and restores position 0.
    psif.ps_en = 1'b1;
    psif.ps_incdec = 1'b1;
    tick();
    psif.ps_en = 1'b0;
    for (int i = 2; i <= 6; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_busy", psif.busy, 0);
    chk("rst_mid_pos", phase_pos, 0);
    chk("rst_mid_done", psif.ps_done, 0);
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      if (psif.ps_done) dones++;
      tick();
    end
    chk("rst_mid_no_done", dones, 0);
    model = 0;
    do_step(1'b1, 0, "after_rst");

    // Random inc/dec stream against the modulo model.
    for (int i = 0; i < 60; i++) do_step(1'($urandom_range(0, 1)), 0, "rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got 1, expected 0");
    $fatal(1, "timeout");
  end
endmodule
